sat_arbiter: RTL and testbench

Time-multiplexes one shared `saturation` datapath among K requesters (e.g. id PI, iq PI and speed-loop integrators of the FOC core). Each requester has its own programmable signed max/min limit pair. A round-robin arbiter grants one request per cycle, and the result leaves through a single registered output port with the requester id, saturation flags and valid/ready backpressure. The block sits between the PI controllers and their integrator/output registers.

---
 rtl/sat_arbiter_pkg.sv | 33 +++
 rtl/sat_arbiter_if.sv | 36 +++
 rtl/saturation.sv | 28 ++
 rtl/sat_arbiter.sv | 126 ++++++++++++
 tb/tb_sat_arbiter.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/sat_arbiter_pkg.sv
// Shared types, reset constants and the round-robin pick function for sat_arbiter.
package sat_arbiter_pkg;

  localparam int SAT_N  = 10;
  localparam int SAT_F  = 9;
  localparam int SAT_K  = 3;
  localparam int SAT_IW = $clog2(SAT_K);

  typedef logic signed [SAT_N-1:0] data_t;

  // Full-scale limits: a requester with untouched limits never saturates.
  localparam data_t SAT_MAX_RST = data_t'((1 << (SAT_N - 1)) - 1);
  localparam data_t SAT_MIN_RST = data_t'(-(1 << (SAT_N - 1)));

  // One-hot grant for the first valid requester at or after ptr, wrapping modulo K.
  function automatic logic [SAT_K-1:0] rr_pick(input logic [SAT_K-1:0]  valid,
                                               input logic [SAT_IW-1:0] ptr);
    logic [SAT_K-1:0] grant;
    logic             found;
    int               idx;
    grant = '0;
    found = 1'b0;
    for (int off = 0; off < SAT_K; off++) begin
      idx = (int'(ptr) + off) % SAT_K;
      if (!found && valid[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/sat_arbiter_if.sv
// Request, limit-configuration and result port bundle for sat_arbiter.
interface sat_arbiter_if #(
  parameter int N = 10,
  parameter int K = 3
);
  localparam int IW = $clog2(K);

  logic [K-1:0]        req_valid;
  logic [K-1:0][N-1:0] req_x;
  logic [K-1:0]        req_ready;

  logic                cfg_we;
  logic [IW-1:0]       cfg_sel;
  logic [N-1:0]        cfg_max;
  logic [N-1:0]        cfg_min;
  logic                cfg_err;

  logic                out_valid;
  logic                out_ready;
  logic [IW-1:0]       out_id;
  logic [N-1:0]        out_y;
  logic                out_sat_hi;
  logic                out_sat_lo;

  // Requesters, configuration master and downstream consumer.
  modport master (
    output req_valid, req_x, cfg_we, cfg_sel, cfg_max, cfg_min, out_ready,
    input  req_ready, cfg_err, out_valid, out_id, out_y, out_sat_hi, out_sat_lo
  );

  // The arbiter itself.
  modport slave (
    input  req_valid, req_x, cfg_we, cfg_sel, cfg_max, cfg_min, out_ready,
    output req_ready, cfg_err, out_valid, out_id, out_y, out_sat_hi, out_sat_lo
  );
endinterface

// File: rtl/saturation.sv
// Signed clamp of x into [min, max]; F is the fixed-point format, carried only.
module saturation #(
  parameter int N = 10,
  parameter int F = 9
) (
  input  logic signed [N-1:0] x_i,
  input  logic signed [N-1:0] max_i,
  input  logic signed [N-1:0] min_i,
  output logic signed [N-1:0] y_o,
  output logic                sat_hi_o,
  output logic                sat_lo_o
);

  // The fraction point does not move the comparison, only names the format.
  if (F >= N) begin : g_frac_wider_than_word
  end

  assign sat_hi_o = (x_i > max_i);
  assign sat_lo_o = (x_i < min_i);

  // Clamp: hi and lo cannot both be set while min <= max holds.
  always_comb begin
    if (sat_hi_o)      y_o = max_i;
    else if (sat_lo_o) y_o = min_i;
    else               y_o = x_i;
  end

endmodule

// File: rtl/sat_arbiter.sv
// Round-robin arbiter sharing one saturation datapath among K requesters,
// each with its own programmable limit pair, behind one registered result port.
module sat_arbiter
  import sat_arbiter_pkg::*;
#(
  parameter int N = SAT_N,
  parameter int F = SAT_F,
  parameter int K = SAT_K
) (
  input  logic         clk,
  input  logic         rst,
  sat_arbiter_if.slave bus
);

  localparam int IW = $clog2(K);

  logic signed [N-1:0] max_q [K];
  logic signed [N-1:0] min_q [K];
  logic [IW-1:0]       rr_ptr_q, rr_ptr_d;
  logic                cfg_err_q;

  logic                out_valid_q;
  logic [IW-1:0]       out_id_q;
  logic signed [N-1:0] out_y_q;
  logic                out_sat_hi_q, out_sat_lo_q;

  logic                can_issue;
  logic [K-1:0]        grant;
  logic                xfer;
  logic [IW-1:0]       grant_idx;
  logic signed [N-1:0] x_sel, max_sel, min_sel, y_sat;
  logic                sat_hi, sat_lo;
  logic                cfg_reject;

  assign can_issue = !out_valid_q || bus.out_ready;

  // Grant is combinational so a request can be accepted in the cycle it appears.
  assign grant         = (can_issue && !rst) ? rr_pick(bus.req_valid, rr_ptr_q) : '0;
  assign bus.req_ready = grant;
  assign xfer          = |(grant & bus.req_valid);

  // One-hot grant to index and operand/limit mux for the shared datapath.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
  always_comb begin
    grant_idx = '0;
    x_sel     = '0;
    max_sel   = '0;
    min_sel   = '0;
    for (int i = 0; i < K; i++) begin
      if (grant[i]) begin
        grant_idx = IW'(i);
        x_sel     = $signed(bus.req_x[i]);
        max_sel   = max_q[i];
        min_sel   = min_q[i];
      end
    end
  end

  // Pointer moves past the winner only when a transfer happens.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (xfer) rr_ptr_d = (grant_idx == IW'(K - 1)) ? '0 : grant_idx + 1'b1;
  end

  assign cfg_reject = (int'(bus.cfg_sel) >= K) ||
                      ($signed(bus.cfg_min) > $signed(bus.cfg_max));

  saturation #(.N(N), .F(F)) u_saturation (
    .x_i      (x_sel),
    .max_i    (max_sel),
    .min_i    (min_sel),
    .y_o      (y_sat),
    .sat_hi_o (sat_hi),
    .sat_lo_o (sat_lo)
  );

  // Limit bank and config error pulse; a same-cycle grant already read the old limits.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: the limit bank is a handful of flops, so it is reset to full scale rather than left unknown.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < K; i++) begin
        max_q[i] <= SAT_MAX_RST;
        min_q[i] <= SAT_MIN_RST;
      end
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= bus.cfg_we && cfg_reject;
      if (bus.cfg_we && !cfg_reject) begin
        max_q[bus.cfg_sel] <= $signed(bus.cfg_max);
        min_q[bus.cfg_sel] <= $signed(bus.cfg_min);
      end
    end
  end

  // Round-robin pointer and result register; fields hold while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q     <= '0;
      out_valid_q  <= 1'b0;
      out_id_q     <= '0;
      out_y_q      <= '0;
      out_sat_hi_q <= 1'b0;
      out_sat_lo_q <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      if (xfer) begin
        out_valid_q  <= 1'b1;
        out_id_q     <= grant_idx;
        out_y_q      <= y_sat;
        out_sat_hi_q <= sat_hi;
        out_sat_lo_q <= sat_lo;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.cfg_err    = cfg_err_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_id     = out_id_q;
  assign bus.out_y      = out_y_q;
  assign bus.out_sat_hi = out_sat_hi_q;
  assign bus.out_sat_lo = out_sat_lo_q;

endmodule

// File: tb/tb_sat_arbiter.sv
// Directed self-checking bench for sat_arbiter with hand-computed expectations.
module tb_sat_arbiter;

  localparam int N = 10;
  localparam int K = 3;

  logic clk = 1'b0;
  logic rst;

  int n_checks = 0;
  int n_errors = 0;

  sat_arbiter_if #(.N(N), .K(K)) bus ();

  sat_arbiter #(.N(N), .F(9), .K(K)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [N-1:0] d(input int v);
    return v[N-1:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input int id, input int y,
                           input logic hi, input logic lo);
    check({tag, ".valid"}, 32'(bus.out_valid), 1);
    check({tag, ".id"},    32'(bus.out_id), id);
    check({tag, ".y"},     32'($signed(bus.out_y)), y);
    check({tag, ".hi"},    32'(bus.out_sat_hi), 32'(hi));
    check({tag, ".lo"},    32'(bus.out_sat_lo), 32'(lo));
  endtask

  task automatic cfg(input logic we, input int sel, input int mx, input int mn);
    bus.cfg_we  = we;
    bus.cfg_sel = sel[1:0];
    bus.cfg_max = d(mx);
    bus.cfg_min = d(mn);
  endtask

  int rr_ids [6] = '{2, 0, 1, 2, 0, 1};

  initial begin
    rst           = 1'b1;
    bus.req_valid = 3'b111;
    bus.req_x     = '0;
    bus.out_ready = 1'b1;
    cfg(1'b0, 0, 0, 0);
    #2;
    check("rst.valid",   32'(bus.out_valid), 0);
    check("rst.ready",   32'(bus.req_ready), 0);
    check("rst.cfg_err", 32'(bus.cfg_err), 0);
    check("rst.y",       32'($signed(bus.out_y)), 0);
    tick();
    tick();

    // Full-scale limits pass the extremes untouched.
    rst           = 1'b0;
    bus.req_valid = 3'b001;
    bus.req_x[0]  = d(511);
    #1;
    check("fs.ready", 32'(bus.req_ready), 32'b001);
    tick();
    check_out("fs.max", 0, 511, 1'b0, 1'b0);
    bus.req_x[0] = d(-512);
    tick();
    check_out("fs.min", 0, -512, 1'b0, 1'b0);

    // Program ch1 to +-256 and saturate both ways.
    bus.req_valid = 3'b000;
    cfg(1'b1, 1, 256, -256);
    tick();
    check("cfg1.drain", 32'(bus.out_valid), 0);
    check("cfg1.err",   32'(bus.cfg_err), 0);
    cfg(1'b0, 0, 0, 0);
    bus.req_valid = 3'b010;
    bus.req_x[1]  = d(300);
    tick();
    check_out("ch1.hi", 1, 256, 1'b1, 1'b0);
    bus.req_x[1] = d(-400);
    tick();
    check_out("ch1.lo", 1, -256, 1'b0, 1'b1);
    bus.req_x[1] = d(100);
    tick();
    check_out("ch1.in", 1, 100, 1'b0, 1'b0);

    // All requesting: pointer sits at 2 after the ch1 grant.
    bus.req_valid = 3'b111;
    bus.req_x[0]  = d(10);
    bus.req_x[1]  = d(20);
    bus.req_x[2]  = d(30);
    for (int i = 0; i < 6; i++) begin
      tick();
      check_out($sformatf("rr%0d", i), rr_ids[i], (rr_ids[i] + 1) * 10, 1'b0, 1'b0);
    end

    // Stall the output for 5 cycles.
    bus.out_ready = 1'b0;
    #1;
    check("stall.ready0", 32'(bus.req_ready), 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_out($sformatf("stall%0d", i), 1, 20, 1'b0, 1'b0);
      check($sformatf("stall%0d.ready", i), 32'(bus.req_ready), 0);
    end
    bus.out_ready = 1'b1;
    #1;
    check("release.ready", 32'(bus.req_ready), 32'b100);
    tick();
    check_out("release", 2, 30, 1'b0, 1'b0);
    bus.req_valid = 3'b000;
    tick();
    check("idle.valid", 32'(bus.out_valid), 0);

    // Rejected writes: min > max, and out-of-range selector.
    cfg(1'b1, 0, 50, 100);
    tick();
    check("rej1.err", 32'(bus.cfg_err), 1);
    cfg(1'b0, 0, 0, 0);
    tick();
    check("rej1.pulse", 32'(bus.cfg_err), 0);
    cfg(1'b1, 3, 10, 0);
    tick();
    check("rej2.err", 32'(bus.cfg_err), 1);
    cfg(1'b0, 0, 0, 0);
    bus.req_valid = 3'b001;
    bus.req_x[0]  = d(511);
    tick();
    check("rej2.pulse", 32'(bus.cfg_err), 0);
    check_out("rej.ch0", 0, 511, 1'b0, 1'b0);
    bus.req_valid = 3'b010;
    bus.req_x[1]  = d(300);
    tick();
    check_out("rej.ch1", 1, 256, 1'b1, 1'b0);

    // Same-cycle write and grant on ch2: the grant sees the old limits.
    bus.req_valid = 3'b100;
    bus.req_x[2]  = d(200);
    cfg(1'b1, 2, 100, -100);
    tick();
    check_out("same.old", 2, 200, 1'b0, 1'b0);
    check("same.err", 32'(bus.cfg_err), 0);
    cfg(1'b0, 0, 0, 0);
    tick();
    check_out("same.new", 2, 100, 1'b1, 1'b0);

    // Asynchronous reset with a held result.
    bus.out_ready = 1'b0;
    bus.req_valid = 3'b111;
    #3;
    rst = 1'b1;
    #1;
    check("arst.valid", 32'(bus.out_valid), 0);
    check("arst.y",     32'($signed(bus.out_y)), 0);
    check("arst.id",    32'(bus.out_id), 0);
    check("arst.hi",    32'(bus.out_sat_hi), 0);
    check("arst.ready", 32'(bus.req_ready), 0);
    tick();
    tick();
    rst           = 1'b0;
    bus.out_ready = 1'b1;
    bus.req_x[0]  = d(7);
    bus.req_x[1]  = d(300);
    bus.req_x[2]  = d(200);
    #1;
    check("post.ready", 32'(bus.req_ready), 32'b001);
    tick();
    check_out("post.ch0", 0, 7, 1'b0, 1'b0);
    tick();
    check_out("post.ch1", 1, 300, 1'b0, 1'b0);
    tick();
    check_out("post.ch2", 2, 200, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
